hex_display_pager: RTL and testbench
====================================

// Module: hex_display_pager
// PURPOSE
//  Board-side consumer of the CPU's 32-bit debug_hex_display word.
//  Shows one 16-bit half of the word at a time on the four 7-seg digits HEX3..HEX0.
//  Takes debounced KEY presses to switch half (page) and to freeze/unfreeze a snapshot.
//  Instantiated in the board top next to master; driven by the same clock.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_250_000    cycles a key must hold a new level before accepted (10 ms @125 MHz)
//  SCROLL_CYCLES    125_000_000  auto page-flip period in cycles; used only with HEX_AUTOSCROLL_EN
// PORTS
//  external_clk  in   1   single system clock, all logic on rising edge
//  rst           in   1   synchronous, active-high reset
//  value_in      in   32  live debug word from master.debug_hex_display
//  key_page_n    in   1   raw push-button, active-low: toggle displayed half
//  key_freeze_n  in   1   raw push-button, active-low: toggle freeze
//  hex0..hex3    out  7   segments {g,f,e,d,c,b,a}, active-low; hex0 = least significant nibble
//  page_led      out  1   0 = bits[15:0] shown, 1 = bits[31:16] shown
//  frozen_led    out  1   1 = snapshot shown instead of live value
// BEHAVIOUR
//  Reset: hex0..hex3 = 7'h7F (blank), page_led = 0, frozen_led = 0.
//   Snapshot = 0, debounced key states = released (1), all counters = 0.
//  Input path: each key passes through a 2-FF synchronizer, then the debouncer.
//  Debouncer, per key:
//   - Counter increments while the synced level differs from the debounced level.
//   - Any cycle the synced level equals the debounced level clears the counter (glitch restarts).
//   - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
//   - A debounced 1->0 flip emits a 1-cycle press pulse; release emits nothing.
//  Page: a page press pulse toggles page_led on the next edge.
//  Freeze, on a freeze press pulse:
//   - If not frozen: snapshot <= value_in sampled that same cycle; frozen_led <= 1.
//   - If frozen: frozen_led <= 0; the snapshot is retained but unused.
//  Page and freeze pulses on the same cycle: both take effect on that edge.
//  Display source: src = frozen ? snapshot : value_in.
//   nib = page ? src[31:16] : src[15:0].
//   hexN <= seg(nib[4N+3:4N]) every cycle (registered).
//   Latency value_in -> hex outputs = 1 cycle when live.
//   After a page or freeze toggle, the new content appears 1 cycle after page_led/frozen_led change.
//  seg() hex-digit map, active-low:
//   0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
//   8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E
//  Reset mid-debounce or mid-operation: all state returns to reset values.
//   No press pulse is emitted as a result of reset.
//   A key held down across reset release is accepted as a press after DEBOUNCE_CYCLES (+2 sync cycles).
// CONFIGURATION
//  HEX_AUTOSCROLL_EN defined:
//   - A scroll counter counts 0..SCROLL_CYCLES-1.
//   - On wrap the page toggles, unless frozen; while frozen the counter is held at 0.
//   - A manual page press toggles the page and clears the counter.
//   - Press and wrap on the same cycle produce a single toggle.
//  HEX_AUTOSCROLL_EN undefined: no scroll counter; the page changes only on page presses.
// TESTING  (DEBOUNCE_CYCLES=4, SCROLL_CYCLES=16 in bench)
//  1. rst 2 cycles, value_in=32'h1234_ABCD, keys high.
//     -> hex outputs 7F during reset.
//     -> 1 cycle after reset: hex3..hex0 = 08,03,46,21 (A b C d); page_led=0.
//  2. key_page_n low for 10 cycles.
//     -> page_led=1 exactly 2+4 cycles after the fall.
//     -> next cycle hex3..hex0 = 79,24,30,19 (1 2 3 4). Release produces no toggle.
//  3. key_page_n low pulses of 1-3 cycles separated by high cycles.
//     -> page_led never changes.
//  4. Freeze press with value_in=32'hDEAD_BEEF, then value_in changes every cycle.
//     -> frozen_led=1; display stays on the snapshot halves.
//     -> second freeze press restores live tracking with 1-cycle latency.
//  5. Page and freeze keys fall on the same cycle.
//     -> page_led and frozen_led toggle on the same edge.
//     -> assert rst mid-debounce: no toggle after reset release.
//  6. HEX_AUTOSCROLL_EN build: page_led toggles every 16 cycles.
//     -> a manual press restarts the period.
//     -> while frozen, no auto toggles occur.

Source files
------------

// File: rtl/hex_display_pager.sv
// hex_display_pager: pages/freezes a 32-bit debug word onto four active-low 7-seg digits.
// Define HEX_AUTOSCROLL_EN to also flip pages automatically every SCROLL_CYCLES while live.
module hex_display_pager #(
  parameter int DEBOUNCE_CYCLES = 1_250_000,
  parameter int SCROLL_CYCLES   = 125_000_000
) (
  input  logic        external_clk,
  input  logic        rst,
  input  logic [31:0] value_in,
  input  logic        key_page_n,
  input  logic        key_freeze_n,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic        page_led,
  output logic        frozen_led
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  logic [1:0]    sync1_q, sync2_q, db_q, db_d, flip, press;
  logic [DW-1:0] cnt_q [2];
  logic [DW-1:0] cnt_d [2];
  logic          page_q, page_d, frozen_q, frozen_d;
  logic [31:0]   snap_q, snap_d, src;
  logic [15:0]   half;
  logic [6:0]    hex_q [4];
  logic [6:0]    hex_d [4];
  // bit 0 is the page key, bit 1 the freeze key
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      flip[k]  = sync2_q[k] != db_q[k] && cnt_q[k] == DW'(DEBOUNCE_CYCLES - 1);
      db_d[k]  = flip[k] ? sync2_q[k] : db_q[k];
      cnt_d[k] = (sync2_q[k] == db_q[k] || flip[k]) ? '0 : cnt_q[k] + 1'b1;
      press[k] = flip[k] & ~sync2_q[k];
    end
  end
  always_comb begin
    frozen_d = press[1] ? ~frozen_q : frozen_q;
    snap_d   = (press[1] & ~frozen_q) ? value_in : snap_q;
    src      = frozen_q ? snap_q : value_in;
    half     = page_q ? src[31:16] : src[15:0];
    for (int n = 0; n < 4; n++) hex_d[n] = SEG[half[4*n +: 4]];
  end
`ifdef HEX_AUTOSCROLL_EN
  localparam int SW = $clog2(SCROLL_CYCLES + 1);
  logic [SW-1:0] scroll_q, scroll_d;
  logic          wrap;
  // a manual press and a wrap on the same cycle collapse into one toggle
  always_comb begin
    wrap     = ~frozen_q && scroll_q == SW'(SCROLL_CYCLES - 1);
    page_d   = page_q ^ (press[0] | wrap);
    scroll_d = (press[0] | frozen_q | wrap) ? '0 : scroll_q + 1'b1;
  end
  always_ff @(posedge external_clk) scroll_q <= rst ? '0 : scroll_d;
`else
  logic unused_scroll;
  assign unused_scroll = ^SCROLL_CYCLES;
  assign page_d = page_q ^ press[0];
`endif
  always_ff @(posedge external_clk) begin
    if (rst) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      db_q     <= '1;
      cnt_q    <= '{default: '0};
      page_q   <= 1'b0;
      frozen_q <= 1'b0;
      snap_q   <= '0;
      hex_q    <= '{default: 7'h7F};
    end else begin
      sync1_q  <= {key_freeze_n, key_page_n};
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      cnt_q    <= cnt_d;
      page_q   <= page_d;
      frozen_q <= frozen_d;
      snap_q   <= snap_d;
      hex_q    <= hex_d;
    end
  end
  assign hex0       = hex_q[0];
  assign hex1       = hex_q[1];
  assign hex2       = hex_q[2];
  assign hex3       = hex_q[3];
  assign page_led   = page_q;
  assign frozen_led = frozen_q;
endmodule

// File: tb/tb_hex_display_pager.sv
// tb_hex_display_pager: directed plus random key/value stimulus against a window-based behavioural model.
module tb_hex_display_pager;
  localparam int DEB = 4;
  localparam int SCR = 16;
  logic        clk = 1'b0, rst = 1'b1, kp = 1'b1, kf = 1'b1;
  logic [31:0] val = 32'h0;
  logic [6:0]  h0, h1, h2, h3;
  logic        pl, fl;
  int          n_chk = 0, n_fail = 0;

  hex_display_pager #(.DEBOUNCE_CYCLES(DEB), .SCROLL_CYCLES(SCR)) dut (
    .external_clk(clk), .rst(rst), .value_in(val),
    .key_page_n(kp), .key_freeze_n(kf),
    .hex0(h0), .hex1(h1), .hex2(h2), .hex3(h3),
    .page_led(pl), .frozen_led(fl)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_t [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  logic [6:0]     m_hex [4];
  logic           m_page, m_frz, acc_p, acc_f;
  logic [31:0]    m_snap;
  logic [DEB+1:0] hp, hf;
  int             age;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // A key level is accepted once the synchronised input (2 cycles old) has
  // disagreed with the accepted level for DEB consecutive samples.
  task automatic model_edge();
    logic [31:0] src;
    logic [15:0] hv;
    logic        fp, ff, pp, pf;
    if (rst) begin
      hp = '1; hf = '1; acc_p = 1'b1; acc_f = 1'b1;
      m_page = 1'b0; m_frz = 1'b0; m_snap = 32'h0; age = 0;
      for (int i = 0; i < 4; i++) m_hex[i] = 7'h7F;
    end else begin
      src = m_frz ? m_snap : val;
      hv  = m_page ? src[31:16] : src[15:0];
      for (int i = 0; i < 4; i++) m_hex[i] = seg_t[(hv >> (4 * i)) & 16'hF];
      hp = {hp[DEB:0], kp};
      hf = {hf[DEB:0], kf};
      fp = hp[DEB+1:2] == {DEB{~acc_p}};
      ff = hf[DEB+1:2] == {DEB{~acc_f}};
      if (fp) acc_p = ~acc_p;
      if (ff) acc_f = ~acc_f;
      pp = fp && !acc_p;
      pf = ff && !acc_f;
`ifdef HEX_AUTOSCROLL_EN
      if (pp) begin m_page = ~m_page; age = 0; end
      else if (m_frz) age = 0;
      else if (age == SCR - 1) begin m_page = ~m_page; age = 0; end
      else age++;
`else
      if (pp) m_page = ~m_page;
`endif
      if (pf) begin
        if (!m_frz) begin m_snap = val; m_frz = 1'b1; end
        else m_frz = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("page_led", 32'(pl), 32'(m_page));
    chk("frozen_led", 32'(fl), 32'(m_frz));
    chk("hex0", 32'(h0), 32'(m_hex[0]));
    chk("hex1", 32'(h1), 32'(m_hex[1]));
    chk("hex2", 32'(h2), 32'(m_hex[2]));
    chk("hex3", 32'(h3), 32'(m_hex[3]));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int lat, lat_p, lat_f, rp, rf, tog;
    logic prev;
    // reset and first display
    val = 32'h1234_ABCD;
    steps(2);
    chk("reset_hex0", 32'(h0), 32'h7F);
    chk("reset_hex3", 32'(h3), 32'h7F);
    chk("reset_page", 32'(pl), 32'h0);
    rst = 1'b0;
    step();
    chk("live_hex3", 32'(h3), 32'h08);
    chk("live_hex2", 32'(h2), 32'h03);
    chk("live_hex1", 32'(h1), 32'h46);
    chk("live_hex0", 32'(h0), 32'h21);
`ifndef HEX_AUTOSCROLL_EN
    // page press latency
    kp = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (pl && lat == 0) lat = i;
    end
    chk("page_latency", 32'(lat), 32'd6);
    chk("hi_hex3", 32'(h3), 32'h79);
    chk("hi_hex2", 32'(h2), 32'h24);
    chk("hi_hex1", 32'(h1), 32'h30);
    chk("hi_hex0", 32'(h0), 32'h19);
    kp = 1'b1;
    steps(10);
    chk("release_no_toggle", 32'(pl), 32'h1);
    // short glitches
    for (int len = 1; len <= 3; len++) begin
      kp = 1'b0; steps(len);
      kp = 1'b1; steps(3);
    end
    chk("glitch_no_toggle", 32'(pl), 32'h1);
    // freeze on DEAD_BEEF then live values every cycle
    val = 32'hDEAD_BEEF;
    kf = 1'b0;
    steps(7);
    kf = 1'b1;
    for (int i = 0; i < 12; i++) begin val = $urandom; step(); end
    chk("frozen_on", 32'(fl), 32'h1);
    chk("frozen_hex3", 32'(h3), 32'h21);
    chk("frozen_hex0", 32'(h0), 32'h21);
    kf = 1'b0;
    for (int i = 0; i < 7; i++) begin val = $urandom; step(); end
    kf = 1'b1;
    for (int i = 0; i < 10; i++) begin val = $urandom; step(); end
    chk("frozen_off", 32'(fl), 32'h0);
    // simultaneous page and freeze presses
    kp = 1'b0; kf = 1'b0;
    lat_p = 0; lat_f = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (!pl && lat_p == 0) lat_p = i;
      if (fl && lat_f == 0) lat_f = i;
    end
    chk("both_same_edge", 32'(lat_p), 32'(lat_f));
    chk("both_latency", 32'(lat_f), 32'd6);
    kp = 1'b1; kf = 1'b1;
    steps(10);
    // reset in the middle of a debounce
    kp = 1'b0; kf = 1'b0;
    steps(3);
    rst = 1'b1; steps(2);
    kp = 1'b1; kf = 1'b1; rst = 1'b0;
    steps(10);
    chk("mid_reset_page", 32'(pl), 32'h0);
    chk("mid_reset_frozen", 32'(fl), 32'h0);
    // key held down across reset release
    kp = 1'b0;
    rst = 1'b1; steps(2);
    rst = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (pl && lat == 0) lat = i;
    end
    chk("held_across_reset", 32'(lat), 32'd6);
    kp = 1'b1;
    steps(10);
`else
    // auto scroll: toggles on the 16th and 32nd edge after reset
    rst = 1'b1; steps(2); rst = 1'b0;
    tog = 0; prev = pl;
    for (int i = 0; i < 40; i++) begin
      step();
      if (pl != prev) tog++;
      prev = pl;
    end
    chk("auto_toggles", 32'(tog), 32'd2);
    kf = 1'b0; steps(7); kf = 1'b1;
    tog = 0; prev = pl;
    for (int i = 0; i < 40; i++) begin
      step();
      if (pl != prev) tog++;
      prev = pl;
    end
    chk("frozen_no_auto", 32'(tog), 32'd0);
    kf = 1'b0; steps(7); kf = 1'b1;
    steps(5);
    kp = 1'b0; steps(8); kp = 1'b1;
    steps(30);
`endif
    // random keys and values against the model
    rp = 0; rf = 0;
    for (int i = 0; i < 400; i++) begin
      if (rp == 0) begin kp = 1'($urandom_range(0, 1)); rp = $urandom_range(1, 8); end
      if (rf == 0) begin kf = 1'($urandom_range(0, 1)); rf = $urandom_range(1, 8); end
      rp--; rf--;
      val = $urandom;
      if (i == 200) rst = 1'b1;
      if (i == 202) rst = 1'b0;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
